dmem_responder: RTL

Data-memory responder that services load/store requests issued by the CPU_5Stage MEM stage (the initiator) over a valid/ready request channel and a valid/ready response channel. It holds the word array `mem`, which the bench can preload and inspect hierarchically. It inserts a programmable fixed wait-state latency so the pipeline's stall path is exercised. It handles one outstanding transaction at a time.

---
 rtl/dmem_if.sv | 33 +++
 rtl/dmem_responder.sv | 131 +++++++++++++
 2 files changed

// File: rtl/dmem_if.sv
// Load/store request and response channels between the MEM-stage initiator and the data memory.
// Defining DMEM_ALIGN_CHECK_EN adds the resp_err response signal.
interface dmem_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
`ifdef DMEM_ALIGN_CHECK_EN
  logic        resp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );
  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
`else
  modport master (
    output req_valid, req_we, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata
  );
  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata
  );
`endif
endinterface

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder with a fixed LATENCY-cycle wait before each response.
// Defining DMEM_ALIGN_CHECK_EN rejects misaligned requests with resp_err instead of accessing memory.
module dmem_responder #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic   clk,
  input  logic   reset,
  dmem_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            we_q, we_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            commit;
  logic            misaligned;
  logic            mem_we;

  logic [31:0]     mem [DEPTH];

`ifdef DMEM_ALIGN_CHECK_EN
  logic [1:0]      off_q, off_d;
  logic            err_q, err_d;

  assign misaligned = (off_q != 2'b00);
  assign bus.resp_err = err_q;
  wire unused_addr_bits = &{1'b0, bus.req_addr[31:AW+2]};
`else
  assign misaligned = 1'b0;
  wire unused_addr_bits = &{1'b0, bus.req_addr[31:AW+2], bus.req_addr[1:0]};
`endif

  // Every request passes through WAIT so the response lands exactly LATENCY edges after acceptance.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    commit  = 1'b0;
`ifdef DMEM_ALIGN_CHECK_EN
    off_d   = off_q;
    err_d   = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          we_d    = bus.req_we;
          idx_d   = bus.req_addr[AW+1:2];
          wdata_d = bus.req_wdata;
          cnt_d   = CW'(LATENCY - 1);
`ifdef DMEM_ALIGN_CHECK_EN
          off_d   = bus.req_addr[1:0];
`endif
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          state_d = RESP;
          commit  = 1'b1;
          if (misaligned) begin
            rdata_d = 32'd0;
          end else begin
            rdata_d = we_q ? wdata_q : mem[idx_q];
          end
`ifdef DMEM_ALIGN_CHECK_EN
          err_d = misaligned;
`endif
        end
      end
      RESP: begin
        if (bus.resp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      idx_q   <= '0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
`ifdef DMEM_ALIGN_CHECK_EN
      off_q   <= 2'b00;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
`ifdef DMEM_ALIGN_CHECK_EN
      off_q   <= off_d;
      err_q   <= err_d;
`endif
    end
  end

  // Commit is gated by state_q, so reset forcing IDLE discards any store still waiting.
  assign mem_we = commit & we_q & ~misaligned;

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[idx_q] <= wdata_q;
    end
  end

  assign bus.req_ready  = (state_q == IDLE);
  assign bus.resp_valid = (state_q == RESP);
  assign bus.resp_rdata = rdata_q;

endmodule
